// File: rtl/trigger_latch_bank_pkg.sv
// Shared types and helpers for the trigger latch bank.
package tow_pkg;

  // Width of the post-clear holdoff counter; it never wraps.
  localparam int HOLDOFF_W = 8;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_LATCHED  = 2'd2,
    ST_HOLDOFF  = 2'd3
  } tlb_state_t;

  // Index width for n channels; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/trigger_latch_bank_prio_enc.sv
// Lowest-index priority encoder: one-hot, index, any-set and more-than-one-set.
module tlb_prio_enc
  import tow_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int IDXW     = idx_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] vec,
  output logic [CHANNELS-1:0] onehot,
  output logic [IDXW-1:0]     idx,
  output logic                any,
  output logic                multi
);

  // Scan upward; the first set bit wins, any later set bit flags multi.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a value unassigned (no latch).
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    multi  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (vec[i]) begin
        if (any) begin
          multi = 1'b1;
        end else begin
          onehot[i] = 1'b1;
          idx       = IDXW'(i);
          any       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/trigger_latch_bank.sv
// Multi-channel trigger latch: rising-edge capture with arm/capture/clear FSM,
// optional first-press-wins arbitration and a post-clear holdoff.
module trigger_latch_bank
  import tow_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int EXCLUSIVE = 1,
  parameter int HOLDOFF   = 4,
  localparam int IDXW     = idx_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] trigger,
  input  logic                arm,
  input  logic                clear,
  input  logic [CHANNELS-1:0] clr_ch,
  output logic [CHANNELS-1:0] q,
  output logic [IDXW-1:0]     winner,
  output logic                tie,
  output logic                hit,
  output logic                armed
);

  localparam bit                    EXCL      = (EXCLUSIVE != 0);
  localparam logic [HOLDOFF_W-1:0]  HOLD_LOAD = (HOLDOFF > 0) ? HOLDOFF_W'(HOLDOFF - 1) : '0;

  tlb_state_t           state_q, state_d;
  logic [HOLDOFF_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0]  prev_q, prev_d;
  logic [CHANNELS-1:0]  q_q, q_d;
  logic [IDXW-1:0]      winner_q, winner_d;
  logic                 tie_q, tie_d;
  logic                 hit_q, hit_d;

  logic [CHANNELS-1:0]  rise;
  logic [CHANNELS-1:0]  rise_onehot;
  logic [IDXW-1:0]      rise_idx;
  logic                 rise_any;
  logic                 rise_multi;
  logic [CHANNELS-1:0]  q_indep;

  // prev resets to all-ones, so a level already high out of reset is not an edge.
  assign rise    = trigger & ~prev_q;
  assign q_indep = (q_q | rise) & ~clr_ch;

  tlb_prio_enc #(
    .CHANNELS (CHANNELS),
    .IDXW     (IDXW)
  ) u_prio_enc (
    .vec    (rise),
    .onehot (rise_onehot),
    .idx    (rise_idx),
    .any    (rise_any),
    .multi  (rise_multi)
  );

  // Next-state and next-output logic; clear overrides everything else.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prev_d   = trigger;
    q_d      = q_q;
    winner_d = winner_q;
    tie_d    = tie_q;
    hit_d    = 1'b0;

    if (clear) begin
      q_d      = '0;
      winner_d = '0;
      tie_d    = 1'b0;
      if (HOLDOFF > 0) begin
        state_d = ST_HOLDOFF;
        cnt_d   = HOLD_LOAD;
      end else begin
        state_d = ST_DISARMED;
        cnt_d   = '0;
      end
    end else begin
      unique case (state_q)
        ST_DISARMED: begin
          if (arm) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (EXCL) begin
            if (rise_any) begin
              q_d      = rise_onehot;
              winner_d = rise_idx;
              tie_d    = rise_multi;
              hit_d    = 1'b1;
              state_d  = ST_LATCHED;
            end
          end else begin
            q_d      = q_indep;
            hit_d    = |(q_indep & ~q_q);
            winner_d = '0;
            tie_d    = 1'b0;
          end
        end
        ST_LATCHED: begin
          // Result holds until clear.
        end
        ST_HOLDOFF: begin
          if (cnt_q == '0) state_d = ST_DISARMED;
          else             cnt_d   = cnt_q - HOLDOFF_W'(1);
        end
        default: state_d = ST_DISARMED;
      endcase
    end
  end

  // State, edge history and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_DISARMED;
      cnt_q    <= '0;
      prev_q   <= '1;
      q_q      <= '0;
      winner_q <= '0;
      tie_q    <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      q_q      <= q_d;
      winner_q <= winner_d;
      tie_q    <= tie_d;
      hit_q    <= hit_d;
    end
  end

  assign q      = q_q;
  assign winner = winner_q;
  assign tie    = tie_q;
  assign hit    = hit_q;
  assign armed  = (state_q == ST_ARMED);

endmodule

// File: tb/tb_trigger_latch_bank.sv
// Scoreboard bench: two instances (exclusive 2-channel, independent 4-channel)
// driven per cycle; a behavioural model pushes expectations, a monitor compares.
module tb_trigger_latch_bank;

  localparam int M_IDLE = 0;
  localparam int M_OPEN = 1;
  localparam int M_WON  = 2;
  localparam int M_COOL = 3;

  typedef struct {
    int          mode;
    int          left;
    logic [15:0] prev;
    logic [15:0] q;
    int          winner;
    bit          tie;
    bit          hit;
  } mdl_t;

  typedef struct {
    logic [1:0] qx;
    logic [3:0] qi;
    int         wx, wi;
    bit         tx, ti, hx, hi, ax, ai;
  } exp_t;

  typedef struct {
    bit         rst_n;
    logic [1:0] tx, cchx;
    bit         ax, cx;
    logic [3:0] ti, cchi;
    bit         ai, ci;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] trig_x = 2'b01, clrch_x = 2'b00, q_x;
  logic       arm_x = 1'b0, clear_x = 1'b0, winner_x, tie_x, hit_x, armed_x;
  logic [3:0] trig_i = 4'b0000, clrch_i = 4'b0000, q_i;
  logic       arm_i = 1'b0, clear_i = 1'b0, tie_i, hit_i, armed_i;
  logic [1:0] winner_i;

  int errors = 0;
  int checks = 0;

  exp_t  exp_q[$];
  exp_t  e;
  mdl_t  mx, mi;
  stim_t s;

  always #5 clk = ~clk;

  trigger_latch_bank #(.CHANNELS(2), .EXCLUSIVE(1), .HOLDOFF(4)) dut_x (
    .clk(clk), .rst(rst), .trigger(trig_x), .arm(arm_x), .clear(clear_x),
    .clr_ch(clrch_x), .q(q_x), .winner(winner_x), .tie(tie_x), .hit(hit_x),
    .armed(armed_x)
  );

  trigger_latch_bank #(.CHANNELS(4), .EXCLUSIVE(0), .HOLDOFF(255)) dut_i (
    .clk(clk), .rst(rst), .trigger(trig_i), .arm(arm_i), .clear(clear_i),
    .clr_ch(clrch_i), .q(q_i), .winner(winner_i), .tie(tie_i), .hit(hit_i),
    .armed(armed_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset(input int ch);
    mdl_t m;
    m.mode   = M_IDLE;
    m.left   = 0;
    m.prev   = 16'((32'h1 << ch) - 1);
    m.q      = '0;
    m.winner = 0;
    m.tie    = 1'b0;
    m.hit    = 1'b0;
    return m;
  endfunction

  // One clock edge of the behavioural rules: 'left' counts cycles remaining until disarm.
  function automatic mdl_t mdl_step(input mdl_t m, input int ch, input bit excl, input int hold,
                                    input logic [15:0] trig, input bit arm, input bit clr,
                                    input logic [15:0] clrch);
    mdl_t        n;
    logic [15:0] mask, rise, nq;
    n      = m;
    mask   = 16'((32'h1 << ch) - 1);
    rise   = trig & ~m.prev & mask;
    n.prev = trig & mask;
    n.hit  = 1'b0;
    if (clr) begin
      n.q      = '0;
      n.winner = 0;
      n.tie    = 1'b0;
      n.mode   = (hold > 0) ? M_COOL : M_IDLE;
      n.left   = hold;
    end else begin
      case (m.mode)
        M_IDLE: if (arm) n.mode = M_OPEN;
        M_OPEN: begin
          if (excl) begin
            if (rise != 0) begin
              for (int i = ch - 1; i >= 0; i--) if (rise[i]) n.winner = i;
              n.q    = 16'(1) << n.winner;
              n.tie  = ($countones(rise) > 1);
              n.hit  = 1'b1;
              n.mode = M_WON;
            end
          end else begin
            nq    = (m.q | rise) & ~clrch & mask;
            n.hit = ((nq & ~m.q) != 0);
            n.q   = nq;
          end
        end
        M_COOL: begin
          n.left = m.left - 1;
          if (n.left == 0) n.mode = M_IDLE;
        end
        default: ;
      endcase
    end
    return n;
  endfunction

  // Apply one cycle of stimulus at the falling edge and queue the post-edge expectation.
  task automatic drive();
    exp_t x;
    @(negedge clk);
    rst     = s.rst_n;
    trig_x  = s.tx;   arm_x = s.ax; clear_x = s.cx; clrch_x = s.cchx;
    trig_i  = s.ti;   arm_i = s.ai; clear_i = s.ci; clrch_i = s.cchi;
    if (!s.rst_n) begin
      mx = mdl_reset(2);
      mi = mdl_reset(4);
    end else begin
      mx = mdl_step(mx, 2, 1'b1, 4,   16'(s.tx), s.ax, s.cx, 16'(s.cchx));
      mi = mdl_step(mi, 4, 1'b0, 255, 16'(s.ti), s.ai, s.ci, 16'(s.cchi));
    end
    x.qx = mx.q[1:0];  x.wx = mx.winner; x.tx = mx.tie; x.hx = mx.hit; x.ax = (mx.mode == M_OPEN);
    x.qi = mi.q[3:0];  x.wi = mi.winner; x.ti = mi.tie; x.hi = mi.hit; x.ai = (mi.mode == M_OPEN);
    exp_q.push_back(x);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".q_x"},      32'(q_x),      0);
    check({tag, ".winner_x"}, 32'(winner_x), 0);
    check({tag, ".tie_x"},    32'(tie_x),    0);
    check({tag, ".hit_x"},    32'(hit_x),    0);
    check({tag, ".armed_x"},  32'(armed_x),  0);
    check({tag, ".q_i"},      32'(q_i),      0);
    check({tag, ".winner_i"}, 32'(winner_i), 0);
    check({tag, ".tie_i"},    32'(tie_i),    0);
    check({tag, ".hit_i"},    32'(hit_i),    0);
    check({tag, ".armed_i"},  32'(armed_i),  0);
  endtask

  // Asynchronous reset between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    mx = mdl_reset(2);
    mi = mdl_reset(4);
    s.rst_n = 1'b0;
    drive();
    s.rst_n = 1'b1;
  endtask

  // Monitor: compare every registered output shortly after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("x.q",      32'(q_x),      32'(e.qx));
        check("x.winner", 32'(winner_x), e.wx);
        check("x.tie",    32'(tie_x),    32'(e.tx));
        check("x.hit",    32'(hit_x),    32'(e.hx));
        check("x.armed",  32'(armed_x),  32'(e.ax));
        check("i.q",      32'(q_i),      32'(e.qi));
        check("i.winner", 32'(winner_i), e.wi);
        check("i.tie",    32'(tie_i),    32'(e.ti));
        check("i.hit",    32'(hit_i),    32'(e.hi));
        check("i.armed",  32'(armed_i),  32'(e.ai));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    s.rst_n = 1'b1; s.tx = 2'b01; s.cchx = 2'b00; s.ax = 1'b0; s.cx = 1'b0;
    s.ti = 4'b0000; s.cchi = 4'b0000; s.ai = 1'b0; s.ci = 1'b0;

    // Power-on reset with channel 0 of the exclusive bank held high.
    #1 rst = 1'b0;
    #1 check_reset_outputs("por");
    mx = mdl_reset(2);
    mi = mdl_reset(4);

    // Held trigger is not an edge; drop and re-raise captures after one edge.
    s.ax = 1'b1; drive();
    s.ax = 1'b0; drive(); drive();
    s.tx = 2'b00; drive();
    s.tx = 2'b01; drive(); drive();

    // Clear, wait out holdoff, re-arm, then simultaneous rise -> tie, late ch1 ignored.
    s.cx = 1'b1; drive();
    s.cx = 1'b0; s.tx = 2'b00; repeat (5) drive();
    s.ax = 1'b1; drive();
    s.ax = 1'b0; drive();
    s.tx = 2'b11; drive(); drive();
    s.tx = 2'b00; drive();
    s.tx = 2'b10; drive(); drive();

    // Arm held through holdoff is ignored until DISARMED is reached.
    s.tx = 2'b00; s.cx = 1'b1; drive();
    s.cx = 1'b0; s.ax = 1'b1; repeat (4) drive();
    drive();
    s.ax = 1'b0; drive();

    // Clear beats a rise on the same edge.
    s.cx = 1'b1; s.tx = 2'b10; drive();
    s.cx = 1'b0; s.tx = 2'b00; repeat (6) drive();

    // Independent bank: ch2 then ch0, then clr_ch on ch2 beats its own rise.
    s.ai = 1'b1; drive();
    s.ai = 1'b0; s.ti = 4'b0100; drive();
    s.ti = 4'b0101; drive(); drive();
    s.ti = 4'b0001; drive();
    s.ti = 4'b0101; s.cchi = 4'b0100; drive();
    s.cchi = 4'b0000; drive();

    // Reset in the middle of the long holdoff; arm must work straight after.
    s.ci = 1'b1; drive();
    s.ci = 1'b0; repeat (10) drive();
    async_reset();
    s.ai = 1'b1; drive();
    s.ai = 1'b0; drive();

    // Randomised traffic on both banks.
    for (int k = 0; k < 600; k++) begin
      s.tx   = 2'($urandom);
      s.cchx = 2'($urandom);
      s.ax   = ($urandom_range(0, 3) == 0);
      s.cx   = ($urandom_range(0, 15) == 0);
      s.ti   = 4'($urandom);
      s.cchi = 4'($urandom) & 4'($urandom);
      s.ai   = ($urandom_range(0, 3) == 0);
      s.ci   = ($urandom_range(0, 99) == 0);
      drive();
      if (k == 300) async_reset();
    end

    s.ax = 1'b0; s.cx = 1'b0; s.ai = 1'b0; s.ci = 1'b0;
    drive();
    @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
